clk_ratio_meter: RTL and testbench

Measures the period and high time of a divided clock generated synchronously from `i_clk`, and reports the recovered division ratio with a lock indication. It is the monitoring counterpart of the programmable clock divider: it sits beside the divider output, or on any synchronously derived slow clock, so control logic and benches can confirm the programmed ratio. It also flags a stopped clock.

---
 rtl/clk_pkg.sv | 19 +
 rtl/edge_rise_det.sv | 26 ++
 rtl/clk_ratio_meter.sv | 149 ++++++++++++++
 tb/tb_clk_ratio_meter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// Shared types and helpers for the clock ratio meter.
// Declarations only, no timing.
// No flow control involved.
package clk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEEK,
    ST_MEASURE,
    ST_LOCKED
  } meas_state_e;

  // Saturation value of a (width+1)-bit period counter: one past the
  // largest reportable period, so reaching it means "no edge in time".
  function automatic int unsigned cnt_sat_val(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/edge_rise_det.sv
// Registered rising-edge detector for a single synchronous signal.
// Latency: o_rise is combinational from i_d against the previous-cycle sample.
// No flow control; samples every cycle.
module edge_rise_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_arst_n,
  input  logic i_d,
  output logic o_rise
);

  logic d_q;

  // Keep last cycle's sample; RST_VAL=1 stops a high level out of reset from looking like an edge.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      d_q <= RST_VAL;
    end else begin
      d_q <= i_d;
    end
  end

  assign o_rise = i_d & ~d_q;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures period/high time of a synchronously derived clock, reports ratio, lock and stop.
// Latency: outputs register on the edge that samples a monitored rising edge (visible next cycle).
// No backpressure: o_valid is a single-cycle pulse that must be consumed when seen.
module clk_ratio_meter
  import clk_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_en,
  input  logic             i_mon_clk,
  output logic [WIDTH-1:0] o_ratio,
  output logic [WIDTH-1:0] o_high_cnt,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_timeout
);

  localparam int CNT_W   = WIDTH + 1;
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]   CNT_SAT   = CNT_W'(cnt_sat_val(WIDTH));
  localparam logic [WIDTH-1:0]   HI_MAX    = '1;
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_CNT);

  meas_state_e        state;
  logic               mon_rise;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   prev_per;
  logic               prev_vld;
  logic [WIDTH-1:0]   hi;
  logic [MATCH_W-1:0] match;
  logic [MATCH_W-1:0] match_nxt;
  logic               cnt_sat;
  logic               meas_act;
  logic               per_same;
  logic               lock_hit;

  // The edge register runs regardless of i_en so re-enabling on a high level is not an edge.
  edge_rise_det #(
    .RST_VAL (1'b1)
  ) u_mon_edge (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_d      (i_mon_clk),
    .o_rise   (mon_rise)
  );

  assign cnt_sat   = (cnt == CNT_SAT);
  assign meas_act  = (state == ST_MEASURE) || (state == ST_LOCKED);
  // prev_vld guards the first period after SEEK, which has nothing to compare against.
  assign per_same  = prev_vld && (cnt == prev_per);
  assign match_nxt = !per_same             ? '0    :
                     (match == MATCH_MAX)  ? match : match + 1'b1;
  assign lock_hit  = (match_nxt == MATCH_MAX);

  // Period and high-time counters: restart at 1 on each rising edge, saturate otherwise.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cnt <= '0;
      hi  <= '0;
    end else if (!i_en) begin
      cnt <= '0;
      hi  <= '0;
    end else if (mon_rise) begin
      cnt <= CNT_W'(1);
      hi  <= WIDTH'(1);
    end else begin
      if (!cnt_sat) begin
        cnt <= cnt + 1'b1;
      end
      if (i_mon_clk && (hi != HI_MAX)) begin
        hi <= hi + 1'b1;
      end
    end
  end

  // Measurement FSM: publishes each completed period, tracks consecutive matches, detects a stopped clock.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state      <= ST_IDLE;
      prev_per   <= '0;
      prev_vld   <= 1'b0;
      match      <= '0;
      o_ratio    <= '0;
      o_high_cnt <= '0;
      o_valid    <= 1'b0;
      o_locked   <= 1'b0;
      o_timeout  <= 1'b0;
    end else if (!i_en) begin
      state      <= ST_IDLE;
      prev_per   <= '0;
      prev_vld   <= 1'b0;
      match      <= '0;
      o_ratio    <= '0;
      o_high_cnt <= '0;
      o_valid    <= 1'b0;
      o_locked   <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          state    <= ST_SEEK;
          prev_vld <= 1'b0;
          match    <= '0;
        end
        ST_SEEK: begin
          if (mon_rise) begin
            state <= ST_MEASURE;
          end
        end
        ST_MEASURE, ST_LOCKED: begin
          if (cnt_sat) begin
            // A rise landing on saturation is treated as SEEK's first edge: counting restarts without a report.
            o_timeout  <= 1'b1;
            o_locked   <= 1'b0;
            o_ratio    <= '0;
            o_high_cnt <= '0;
            match      <= '0;
            prev_per   <= '0;
            prev_vld   <= 1'b0;
            state      <= mon_rise ? ST_MEASURE : ST_SEEK;
          end else if (mon_rise) begin
            o_ratio    <= cnt[WIDTH-1:0];
            o_high_cnt <= hi;
            o_valid    <= 1'b1;
            o_timeout  <= 1'b0;
            match      <= match_nxt;
            prev_per   <= cnt;
            prev_vld   <= 1'b1;
            if (lock_hit) begin
              state    <= ST_LOCKED;
              o_locked <= 1'b1;
            end else begin
              state    <= ST_MEASURE;
              o_locked <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Bench for clk_ratio_meter: table of monitored-clock periods plus hand-driven corner sequences.
// Expected reports are queued when the closing rising edge is driven, checked on o_valid.
// Inputs driven 1 time unit after the rising clock edge, outputs sampled at the same point.
module tb_clk_ratio_meter;

  localparam int WIDTH    = 8;
  localparam int LOCK_CNT = 4;
  localparam int NVEC     = 12;

  typedef struct {
    int per;
    int hi;
    int exp_ratio;
    int exp_high;
    bit exp_lock;
  } vec_t;

  typedef struct {
    int ratio;
    int high;
    bit lock;
  } sb_t;

  logic             i_clk;
  logic             i_arst_n;
  logic             i_en;
  logic             i_mon_clk;
  logic [WIDTH-1:0] o_ratio;
  logic [WIDTH-1:0] o_high_cnt;
  logic             o_valid;
  logic             o_locked;
  logic             o_timeout;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc_n = 0;
  int   last_rise = 0;
  sb_t  sb_q[$];
  vec_t tab[NVEC];

  clk_ratio_meter #(
    .WIDTH    (WIDTH),
    .LOCK_CNT (LOCK_CNT)
  ) dut (
    .i_clk      (i_clk),
    .i_arst_n   (i_arst_n),
    .i_en       (i_en),
    .i_mon_clk  (i_mon_clk),
    .o_ratio    (o_ratio),
    .o_high_cnt (o_high_cnt),
    .o_valid    (o_valid),
    .o_locked   (o_locked),
    .o_timeout  (o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic push(input int r, input int h, input bit l);
    sb_t e;
    e.ratio = r;
    e.high  = h;
    e.lock  = l;
    sb_q.push_back(e);
  endtask

  task automatic tick(input logic mon);
    i_mon_clk = mon;
    @(posedge i_clk);
    #1;
    cyc_n++;
  endtask

  task automatic drive_period(input int per, input int hi);
    last_rise = cyc_n;
    for (int k = 0; k < per; k++) begin
      tick(k < hi);
    end
  endtask

  // n periods starting from SEEK: the first rise only arms, later rises each report.
  task automatic run_periods(input int n, input int per, input int hi);
    for (int k = 0; k < n; k++) begin
      if (k > 0) push(per, hi, k >= LOCK_CNT + 1);
      drive_period(per, hi);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ratio"},   int'(o_ratio),    0);
    chk({tag, "_high"},    int'(o_high_cnt), 0);
    chk({tag, "_valid"},   int'(o_valid),    0);
    chk({tag, "_locked"},  int'(o_locked),   0);
    chk({tag, "_timeout"}, int'(o_timeout),  0);
  endtask

  // Scoreboard consumer: every o_valid must match the oldest queued expectation.
  always @(posedge i_clk) begin
    sb_t e;
    #1;
    if (i_arst_n && (o_valid === 1'b1)) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: ratio %0d high %0d reported, none expected (cycle %0d)",
                 o_ratio, o_high_cnt, cyc_n);
      end else begin
        e = sb_q.pop_front();
        chk("sb_ratio",  int'(o_ratio),    e.ratio);
        chk("sb_high",   int'(o_high_cnt), e.high);
        chk("sb_locked", int'(o_locked),   int'(e.lock));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc_n);
    $fatal(1);
  end

  initial begin
    tab[0]  = '{4, 2, 4, 2, 1'b0};
    tab[1]  = '{4, 2, 4, 2, 1'b0};
    tab[2]  = '{4, 2, 4, 2, 1'b0};
    tab[3]  = '{4, 2, 4, 2, 1'b0};
    tab[4]  = '{4, 2, 4, 2, 1'b1};
    tab[5]  = '{4, 2, 4, 2, 1'b1};
    tab[6]  = '{8, 4, 8, 4, 1'b0};
    tab[7]  = '{8, 4, 8, 4, 1'b0};
    tab[8]  = '{8, 4, 8, 4, 1'b0};
    tab[9]  = '{8, 4, 8, 4, 1'b0};
    tab[10] = '{8, 4, 8, 4, 1'b1};
    tab[11] = '{8, 4, 8, 4, 1'b1};

    i_arst_n  = 1'b0;
    i_en      = 1'b0;
    i_mon_clk = 1'b0;
    tick(1'b0);
    chk_all_zero("reset");

    i_en     = 1'b1;
    i_arst_n = 1'b1;
    tick(1'b0);
    tick(1'b0);

    // Ratio 4 to lock, then ratio 8: lock drops on first 8 and returns after 4 matches.
    for (int i = 0; i < NVEC; i++) begin
      if (i > 0) push(tab[i-1].exp_ratio, tab[i-1].exp_high, tab[i-1].exp_lock);
      drive_period(tab[i].per, tab[i].hi);
    end
    chk("table_drained", sb_q.size(), 0);

    // Stopped clock: one more rise, then held low until timeout.
    push(tab[NVEC-1].exp_ratio, tab[NVEC-1].exp_high, tab[NVEC-1].exp_lock);
    drive_period(4, 2);
    while (cyc_n < last_rise + 256) tick(1'b0);
    chk("tmo_early_timeout", int'(o_timeout), 0);
    chk("tmo_early_locked",  int'(o_locked),  1);
    tick(1'b0);
    chk("tmo_timeout", int'(o_timeout),  1);
    chk("tmo_locked",  int'(o_locked),   0);
    chk("tmo_ratio",   int'(o_ratio),    0);
    chk("tmo_high",    int'(o_high_cnt), 0);

    // Restart: timeout holds through the arming edge and clears on the first report.
    drive_period(4, 2);
    chk("restart_tmo_held", int'(o_timeout), 1);
    push(4, 2, 1'b0);
    drive_period(4, 2);
    chk("restart_tmo_clear", int'(o_timeout), 0);

    // Disable while the monitored clock is high, re-enable while still high.
    push(4, 2, 1'b0);
    tick(1'b1);
    tick(1'b1);
    i_en = 1'b0;
    tick(1'b1);
    chk_all_zero("en_off");
    i_en = 1'b1;
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    chk("en_on_ratio", int'(o_ratio), 0);
    run_periods(6, 4, 2);
    chk("en_relock", int'(o_locked), 1);

    // Asynchronous reset mid-period while locked.
    push(4, 2, 1'b1);
    tick(1'b1);
    tick(1'b1);
    i_arst_n = 1'b0;
    #2;
    chk_all_zero("arst");
    #1;
    i_arst_n = 1'b1;
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    run_periods(6, 4, 2);
    chk("arst_relock", int'(o_locked), 1);

    // Longest reportable period, then one cycle longer.
    push(4, 2, 1'b1);
    drive_period(255, 128);
    push(255, 128, 1'b0);
    drive_period(4, 2);
    chk("p255_no_timeout", int'(o_timeout), 0);
    push(4, 2, 1'b0);
    drive_period(256, 100);
    chk("p256_before_edge", int'(o_timeout), 0);
    drive_period(4, 2);
    chk("p256_timeout", int'(o_timeout), 1);
    chk("p256_ratio",   int'(o_ratio),   0);
    chk("p256_locked",  int'(o_locked),  0);
    push(4, 2, 1'b0);
    drive_period(4, 2);
    chk("p256_recover", int'(o_timeout), 0);
    chk("final_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
